// File: rtl/serial_pkg.sv
// Shared framing constants and state encoding for the byte-link transmitter and receiver.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        PARITY_BIT = 3'd3,
        STOP       = 3'd4
    } tx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Parity bit that makes the total count of ones even (or odd) over data + parity.
    function automatic logic parity_of(input logic [7:0] b, input int mode);
        return (mode == PAR_ODD) ? ~(^b) : (^b);
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small byte FIFO with registered full/empty flags and occupancy count.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               wdata,
    output logic [7:0]               rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_MAX = DEPTH[AW:0];

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;
    logic [AW:0]   count_n;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_comb begin
        count_n = count;
        case ({do_push, do_pop})
            2'b10:   count_n = count + CNT_ONE;
            2'b01:   count_n = count - CNT_ONE;
            default: count_n = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (do_push) wptr <= wptr + PTR_ONE;
            if (do_pop)  rptr <= rptr + PTR_ONE;
            count <= count_n;
            full  <= (count_n == CNT_MAX);
            empty <= (count_n == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/serial_transmitter_data.sv
// Serial framer: FIFO-buffered bytes sent as start, 8 data bits LSB first, optional parity, stop bit(s).
//   state      | meaning
//   IDLE       | line high, waiting for a queued byte
//   START      | start bit (0) on the line
//   DATA       | data bit on the line, LSB first
//   PARITY_BIT | parity bit on the line
//   STOP       | stop bit(s) (1) on the line; may pop the next byte with no gap
module serial_transmitter_data
    import serial_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1,
    parameter int PARITY     = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_byte,
    output logic       out,
    output logic       busy,
    output logic       frame_start
);
    localparam logic [1:0] STOP_LOAD = 2'(STOP_BITS - 1);
    localparam logic [2:0] LAST_IDX  = 3'(DATA_BITS - 1);

    tx_state_t                      state;
    logic [7:0]                     shift;
    logic [2:0]                     bit_idx;
    logic [1:0]                     stop_cnt;
    logic                           par_bit;

    logic                           fifo_full;
    logic                           fifo_empty;
    logic [7:0]                     fifo_rdata;
    logic [$clog2(FIFO_DEPTH):0]    fifo_count;
    logic                           push;
    logic                           pop;

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    assign pop      = !fifo_empty && ((state == IDLE) || (state == STOP && stop_cnt == 2'd0));
    assign busy     = (state != IDLE) || (fifo_count != '0);

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (in_byte),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            out         <= STOP_BIT;
            frame_start <= 1'b0;
            shift       <= '0;
            bit_idx     <= '0;
            stop_cnt    <= '0;
            par_bit     <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            case (state)
                IDLE: begin
                    out <= STOP_BIT;
                end
                START: begin
                    out     <= shift[0];
                    shift   <= {1'b0, shift[7:1]};
                    bit_idx <= '0;
                    state   <= DATA;
                end
                DATA: begin
                    if (bit_idx == LAST_IDX) begin
                        if (PARITY != PAR_NONE) begin
                            out   <= par_bit;
                            state <= PARITY_BIT;
                        end else begin
                            out      <= STOP_BIT;
                            stop_cnt <= STOP_LOAD;
                            state    <= STOP;
                        end
                    end else begin
                        out     <= shift[0];
                        shift   <= {1'b0, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                    end
                end
                PARITY_BIT: begin
                    out      <= STOP_BIT;
                    stop_cnt <= STOP_LOAD;
                    state    <= STOP;
                end
                STOP: begin
                    if (stop_cnt != 2'd0) begin
                        stop_cnt <= stop_cnt - 2'd1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    out   <= STOP_BIT;
                    state <= IDLE;
                end
            endcase
            // A pop overrides the idle/stop handling above and launches the next frame.
            if (pop) begin
                shift       <= fifo_rdata;
                par_bit     <= parity_of(fifo_rdata, PARITY);
                out         <= START_BIT;
                frame_start <= 1'b1;
                state       <= START;
            end
        end
    end

endmodule

// File: tb/tb_serial_transmitter_data.sv
// Directed bench for serial_transmitter_data with a behavioural frame receiver on the line.
module tb_serial_transmitter_data;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       in_valid, in_ready, out, busy, frame_start;
    logic [7:0] in_byte;
    logic       in_valid2, in_ready2, out2, busy2, frame_start2;
    logic [7:0] in_byte2;

    serial_transmitter_data u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_byte(in_byte), .out(out), .busy(busy), .frame_start(frame_start)
    );

    serial_transmitter_data #(.FIFO_DEPTH(4), .STOP_BITS(2), .PARITY(2)) u_dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_byte(in_byte2), .out(out2), .busy(busy2), .frame_start(frame_start2)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic       line_q[$];
    logic       line2_q[$];
    logic [7:0] rx_q[$];
    int         fs_cnt = 0;
    int         fs2_cnt = 0;
    int         rx_ph = 0;
    int         rx_cnt = 0;
    int         rx_ferr = 0;
    logic [7:0] rx_sh;

    // line logging and a simple receiver: idle high, start 0, 8 bits LSB first, stop 1
    always @(negedge clk) begin
        line_q.push_back(out);
        line2_q.push_back(out2);
        if (frame_start)  fs_cnt++;
        if (frame_start2) fs2_cnt++;
        if (reset) begin
            rx_ph = 0;
        end else begin
            case (rx_ph)
                0: if (out == 1'b0) begin rx_ph = 1; rx_cnt = 0; end
                1: begin
                    rx_sh[rx_cnt] = out;
                    rx_cnt++;
                    if (rx_cnt == 8) rx_ph = 2;
                end
                default: begin
                    if (out == 1'b1) rx_q.push_back(rx_sh);
                    else rx_ferr++;
                    rx_ph = 0;
                end
            endcase
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            step();
            k++;
        end
        check_eq(tag, 32'(busy), 32'd0);
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        return 1'b1;
    endfunction

    initial begin
        logic [9:0]  a5_seq;
        logic [11:0] p_seq;
        logic [7:0]  t2_bytes [3];
        logic [7:0]  t3_exp [9];
        logic [7:0]  exp_q[$];
        int base_l, base_r, base_f, nxt, acc_drop, lows, c;
        logic rdy;

        a5_seq = 10'b11_0100_1010;
        p_seq  = 12'b1100_0000_1110;
        t2_bytes[0] = 8'h00; t2_bytes[1] = 8'hFF; t2_bytes[2] = 8'h3C;

        reset = 1'b1; in_valid = 1'b0; in_byte = 8'h00;
        in_valid2 = 1'b0; in_byte2 = 8'h00;
        step(); step();
        check_eq("rst_out", 32'(out), 32'd1);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_frame_start", 32'(frame_start), 32'd0);
        check_eq("rst_out2", 32'(out2), 32'd1);
        reset = 1'b0;
        step(); step();

        // 1: single byte 0xA5
        base_l = line_q.size(); base_r = rx_q.size();
        in_valid = 1'b1; in_byte = 8'hA5;
        step();
        in_valid = 1'b0;
        check_eq("t1_busy_after_push", 32'(busy), 32'd1);
        check_eq("t1_out_before_pop", 32'(out), 32'd1);
        step();
        check_eq("t1_frame_start", 32'(frame_start), 32'd1);
        check_eq("t1_start_bit", 32'(out), 32'd0);
        step();
        check_eq("t1_frame_start_off", 32'(frame_start), 32'd0);
        wait_idle("t1_idle", 40);
        step();
        for (int i = 0; i < 10; i++)
            check_eq($sformatf("t1_bit%0d", i), 32'(line_q[base_l+2+i]), 32'(a5_seq[i]));
        check_eq("t1_idle_high", 32'(line_q[base_l+12]), 32'd1);
        check_eq("t1_rx_count", 32'(rx_q.size() - base_r), 32'd1);
        if (rx_q.size() > base_r) check_eq("t1_rx_byte", 32'(rx_q[base_r]), 32'hA5);

        // 2: three back-to-back bytes, contiguous frames
        base_l = line_q.size(); base_r = rx_q.size(); base_f = fs_cnt;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_byte = t2_bytes[i];
            step();
        end
        in_valid = 1'b0;
        wait_idle("t2_idle", 60);
        step();
        for (int i = 0; i < 30; i++)
            check_eq($sformatf("t2_line%0d", i), 32'(line_q[base_l+2+i]),
                     32'(frame_bit(t2_bytes[i/10], i%10)));
        check_eq("t2_after_high", 32'(line_q[base_l+32]), 32'd1);
        check_eq("t2_frame_starts", 32'(fs_cnt - base_f), 32'd3);
        check_eq("t2_rx_count", 32'(rx_q.size() - base_r), 32'd3);
        for (int i = 0; i < 3; i++)
            if (rx_q.size() > base_r + i)
                check_eq($sformatf("t2_rx%0d", i), 32'(rx_q[base_r+i]), 32'(t2_bytes[i]));

        // 3: FIFO fills while a frame is in flight
        base_r = rx_q.size();
        t3_exp[0] = 8'h55;
        for (int i = 1; i <= 8; i++) t3_exp[i] = 8'(i);
        in_valid = 1'b1; in_byte = 8'h55;
        step();
        in_valid = 1'b0;
        step(); step();
        nxt = 1; acc_drop = -1;
        for (c = 0; c < 300 && nxt <= 8; c++) begin
            in_valid = 1'b1; in_byte = 8'(nxt);
            rdy = in_ready;
            if (!rdy && acc_drop < 0) acc_drop = nxt - 1;
            step();
            if (rdy) nxt++;
        end
        in_valid = 1'b0;
        check_eq("t3_all_accepted", 32'(nxt), 32'd9);
        check_eq("t3_accepted_at_full", 32'(acc_drop), 32'd4);
        wait_idle("t3_idle", 200);
        step();
        check_eq("t3_rx_count", 32'(rx_q.size() - base_r), 32'd9);
        for (int i = 0; i < 9; i++)
            if (rx_q.size() > base_r + i)
                check_eq($sformatf("t3_rx%0d", i), 32'(rx_q[base_r+i]), 32'(t3_exp[i]));

        // 4: reset during data bit 3 of 0x81 with two bytes queued
        base_r = rx_q.size();
        in_valid = 1'b1; in_byte = 8'h81; step();
        in_byte = 8'h11; step();
        in_byte = 8'h22; step();
        in_valid = 1'b0;
        step(); step(); step();
        check_eq("t4_bit3_on_line", 32'(out), 32'd0);
        check_eq("t4_busy_mid", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("t4_out_after_reset", 32'(out), 32'd1);
        check_eq("t4_busy_after_reset", 32'(busy), 32'd0);
        check_eq("t4_in_ready_after_reset", 32'(in_ready), 32'd1);
        base_l = line_q.size();
        repeat (30) step();
        lows = 0;
        for (int i = base_l; i < line_q.size(); i++) if (line_q[i] == 1'b0) lows++;
        check_eq("t4_no_more_frames", 32'(lows), 32'd0);
        check_eq("t4_rx_nothing", 32'(rx_q.size() - base_r), 32'd0);

        // 5: odd parity, two stop bits, byte 0x07
        base_l = line2_q.size(); base_f = fs2_cnt;
        in_valid2 = 1'b1; in_byte2 = 8'h07;
        step();
        in_valid2 = 1'b0;
        c = 0;
        while (busy2 && c < 40) begin step(); c++; end
        check_eq("t5_idle", 32'(busy2), 32'd0);
        check_eq("t5_frame_cycles", 32'(c), 32'd13);
        step();
        for (int i = 0; i < 12; i++)
            check_eq($sformatf("t5_bit%0d", i), 32'(line2_q[base_l+2+i]), 32'(p_seq[i]));
        check_eq("t5_after_high", 32'(line2_q[base_l+14]), 32'd1);
        check_eq("t5_frame_starts", 32'(fs2_cnt - base_f), 32'd1);

        // 6: random push pattern, 1000 bytes through the receiver
        base_r = rx_q.size();
        for (c = 0; c < 30000 && exp_q.size() < 1000; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_byte = 8'($urandom);
            rdy = in_ready;
            step();
            if (rdy && in_valid) exp_q.push_back(in_byte);
        end
        in_valid = 1'b0;
        check_eq("t6_pushed", 32'(exp_q.size()), 32'd1000);
        wait_idle("t6_idle", 20000);
        step();
        check_eq("t6_rx_count", 32'(rx_q.size() - base_r), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (rx_q.size() > base_r + i)
                check_eq($sformatf("t6_rx%0d", i), 32'(rx_q[base_r+i]), 32'(exp_q[i]));
        check_eq("framing_errors", 32'(rx_ferr), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
